spi_px_master: RTL and testbench
================================

// Module: spi_px_master
// PURPOSE
//  SPI initiator (mode 0: CPOL=0, CPHA=0, MSB first, full duplex) on the host/FPGA side of the
//  gray/Sobel chip. Drives the chip's SCK/CS/SDI pins and samples its SDO pin. Each frame sends
//  one DATA_BITS pixel word and captures the DATA_BITS word the chip shifts out in the same frame.
//  Feeds pixel/LFSR-config streams into the chip; returns processed pixels to the host logic.
// PARAMETERS
//  DATA_BITS  24  bits per frame (pixel word width, matches chip pixel width)
//  CLK_DIV    4   clk_i cycles per SCK half-period; >=1; sized so chip-side synchronizers see each edge
//  CS_GAP     2   clk_i cycles CS held high between frames; >=1
// PORTS
//  clk_i        in   1          single clock; all logic on rising edge
//  reset_i      in   1          asynchronous, active-high reset
//  tx_data_i    in   DATA_BITS  word to send, captured on tx_valid_i & tx_ready_o
//  tx_valid_i   in   1          host has a word
//  tx_ready_o   out  1          high only in IDLE; accept = tx_valid_i & tx_ready_o
//  rx_data_o    out  DATA_BITS  word received in the last frame; held until next frame ends
//  rx_valid_o   out  1          1-cycle pulse when rx_data_o updates
//  busy_o       out  1          high from accept until end of GAP
//  spi_sck_o    out  1          SPI clock to chip spi_sck_i; idle low
//  spi_cs_o     out  1          chip select to chip spi_cs_i, active low; idle high
//  spi_sdo_o    out  1          MOSI to chip spi_sdi_i
//  spi_sdi_i    in   1          MISO from chip spi_sdo_o
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; spi_sck_o=0, spi_cs_o=1, spi_sdo_o=0,
//   tx_ready_o=0, rx_valid_o=0, busy_o=0, rx_data_o=0; tx_ready_o rises 1st cycle after release.
//  All outputs registered; no combinational path input->output.
//  FSM: IDLE -> SETUP -> {HIGH -> LOW} x DATA_BITS -> GAP -> IDLE. Half-period counter 0..CLK_DIV-1.
//  IDLE: tx_ready_o=1. On accept: load tx shift reg, bit counter=DATA_BITS-1, go SETUP; tx_ready_o=0,
//   busy_o=1 next cycle. tx_valid_i outside IDLE is ignored (no queueing).
//  SETUP: spi_cs_o=0, spi_sdo_o=tx_data[MSB], sck=0; lasts CLK_DIV cycles, then HIGH.
//  HIGH: spi_sck_o=1 for CLK_DIV cycles; spi_sdi_i sampled into LSB of rx shift reg (shift left)
//   on the LAST cycle of HIGH (max settle time for chip SDO).
//  LOW: spi_sck_o=0 for CLK_DIV cycles; on entry spi_sdo_o = next bit (MSB-1 ...). After the last
//   bit's LOW phase (bit counter 0) go GAP; else decrement bit counter, go HIGH.
//  Final LOW phase is CS hold time; spi_sdo_o then holds bit 0.
//  GAP: spi_cs_o=1, spi_sdo_o=0, sck=0 for CS_GAP cycles. On GAP entry: rx_data_o<=rx shift reg,
//   rx_valid_o=1 for exactly that cycle. Exit GAP -> IDLE (busy_o=0, tx_ready_o=1 same cycle).
//  Timing: CS low = CLK_DIV*(2*DATA_BITS+1) cycles; accept-to-accept min =
//   1 + CLK_DIV*(2*DATA_BITS+1) + CS_GAP cycles (24/4/2 -> 199).
//  Exactly DATA_BITS rising SCK edges per frame; SCK never toggles with CS high.
//  Full duplex: rx word of frame N is whatever chip shifts out during frame N (its previous result).
//  Reset mid-frame: immediately CS high, SCK low, MOSI 0; partial rx discarded; no rx_valid_o pulse.
//  tx_data_i changes after accept do not affect the frame in progress.
// TESTING
//  1 Reset: hold reset_i 5 cycles -> cs=1, sck=0, sdo=0, tx_ready=0; 1 cycle after release tx_ready=1.
//  2 Send 0xA5C3F0, loopback sdo->sdi -> 24 SCK rises, MOSI bits MSB-first match at each rise,
//    rx_valid pulse once, rx_data=0xA5C3F0; CS low exactly 196 cycles.
//  3 Back-to-back: tx_valid held with 0x000001 then 0xFFFFFE -> second accept exactly 199 cycles
//    after first; CS high exactly 2 cycles between frames; rx words match.
//  4 Chip model driving 0x123456 on sdi (changes on SCK fall) -> rx_data=0x123456.
//  5 Assert reset_i at SCK rise #10 -> same cycle cs=1, sck=0; no rx_valid; next frame clean.
//  6 tx_valid pulsed mid-frame with 0xDEAD00 -> ignored; frame data and length unchanged.

Source files
------------

// File: rtl/spi_px_master.sv
// -----------------------------------------------------------------------------
// spi_px_master
//   SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first, full duplex. One frame
//   sends one DATA_BITS word on spi_sdo_o and captures one DATA_BITS word from
//   spi_sdi_i. Frame shape: SETUP (CS low, first bit on MOSI), then DATA_BITS
//   pairs of HIGH/LOW SCK half-periods, then a CS-high GAP before returning to
//   IDLE. The final LOW half-period doubles as CS hold time.
//
// Ports
//   clk_i       single clock, rising edge
//   reset_i     asynchronous active-high reset
//   tx_data_i   word to send, captured on tx_valid_i & tx_ready_o
//   tx_valid_i  host offers a word
//   tx_ready_o  high only while idle
//   rx_data_o   word received in the last completed frame
//   rx_valid_o  one-cycle pulse when rx_data_o updates
//   busy_o      high from accept until the end of the CS gap
//   spi_sck_o   SPI clock, idle low
//   spi_cs_o    chip select, active low, idle high
//   spi_sdo_o   MOSI
//   spi_sdi_i   MISO
// -----------------------------------------------------------------------------
module spi_px_master #(
    parameter int DATA_BITS = 24,
    parameter int CLK_DIV   = 4,
    parameter int CS_GAP    = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 busy_o,
    output logic                 spi_sck_o,
    output logic                 spi_cs_o,
    output logic                 spi_sdo_o,
    input  logic                 spi_sdi_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_BITS + 1);

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [BIT_W-1:0]       bit_reg;
    logic [DATA_BITS-1:0]   tx_shift_reg;
    logic [DATA_BITS-1:0]   rx_shift_reg;

    logic                   half_done;
    logic                   gap_done;
    logic                   accept;
    logic                   sck_next;
    logic                   cs_next;
    logic                   ready_next;
    logic                   busy_next;

    assign half_done = (cnt_reg == CNT_W'(CLK_DIV - 1));
    assign gap_done  = (cnt_reg == CNT_W'(CS_GAP - 1));
    // tx_ready_o (not the state) gates acceptance so that the first cycle
    // after reset release, where the state is IDLE but ready is still low,
    // cannot start a frame.
    assign accept    = tx_valid_i & tx_ready_o;

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and next values of the pin-level outputs. The outputs are
    // registered from the next state so every pin is a flop output that lines
    // up with the state it belongs to.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept)    state_next = S_SETUP;
            S_SETUP: if (half_done) state_next = S_HIGH;
            S_HIGH:  if (half_done) state_next = S_LOW;
            S_LOW:   if (half_done) state_next = (bit_reg == '0) ? S_GAP : S_HIGH;
            S_GAP:   if (gap_done)  state_next = S_IDLE;
            default:                state_next = S_IDLE;
        endcase

        sck_next   = (state_next == S_HIGH);
        cs_next    = !((state_next == S_SETUP) || (state_next == S_HIGH) ||
                       (state_next == S_LOW));
        ready_next = (state_next == S_IDLE);
        busy_next  = (state_next != S_IDLE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_reg      <= '0;
            bit_reg      <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            tx_ready_o   <= 1'b0;
            busy_o       <= 1'b0;
            spi_sck_o    <= 1'b0;
            spi_cs_o     <= 1'b1;
            spi_sdo_o    <= 1'b0;
        end else begin
            spi_sck_o  <= sck_next;
            spi_cs_o   <= cs_next;
            tx_ready_o <= ready_next;
            busy_o     <= busy_next;
            rx_valid_o <= 1'b0;

            // Phase counter restarts on every phase change and rests in IDLE.
            if ((state_next != state_reg) || (state_reg == S_IDLE)) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        tx_shift_reg <= tx_data_i;
                        spi_sdo_o    <= tx_data_i[DATA_BITS-1];
                        bit_reg      <= BIT_W'(DATA_BITS - 1);
                    end
                end
                S_HIGH: begin
                    if (half_done) begin
                        // Sample MISO as late as possible in the high phase.
                        rx_shift_reg <= {rx_shift_reg[DATA_BITS-2:0], spi_sdi_i};
                        // Present the next bit on the falling edge; the last
                        // bit stays on MOSI through the hold phase.
                        if (bit_reg != '0) begin
                            tx_shift_reg <= tx_shift_reg << 1;
                            spi_sdo_o    <= tx_shift_reg[DATA_BITS-2];
                        end
                    end
                end
                S_LOW: begin
                    if (half_done) begin
                        if (bit_reg == '0) begin
                            spi_sdo_o  <= 1'b0;
                            rx_data_o  <= rx_shift_reg;
                            rx_valid_o <= 1'b1;
                        end else begin
                            bit_reg <= bit_reg - BIT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_px_master.sv
// -----------------------------------------------------------------------------
// tb_spi_px_master
//   Self-checking bench for spi_px_master. A checker process predicts every
//   output on every cycle from the accept time and the accepted word (frame
//   position arithmetic), and a simple chip model either loops MOSI back to
//   MISO or shifts out a chosen word, changing its bit on SCK falling edges.
// -----------------------------------------------------------------------------
module tb_spi_px_master;

    localparam int DB     = 24;
    localparam int CD     = 4;
    localparam int CG     = 2;
    localparam int FRAME  = CD * (2 * DB + 1);   // CS-low cycles: 196
    localparam int PERIOD = 1 + FRAME + CG;      // accept-to-accept: 199

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [DB-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
    logic          spi_sck;
    logic          spi_cs;
    logic          spi_sdo;
    logic          spi_sdi;

    // chip model
    logic          loopback = 1'b1;
    logic [DB-1:0] chip_word = '0;
    int            chip_idx = 0;
    logic          chip_prev_cs = 1'b1;
    logic          chip_prev_sck = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    spi_px_master #(
        .DATA_BITS(DB),
        .CLK_DIV  (CD),
        .CS_GAP   (CG)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .tx_data_i (tx_data),
        .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready),
        .rx_data_o (rx_data),
        .rx_valid_o(rx_valid),
        .busy_o    (busy),
        .spi_sck_o (spi_sck),
        .spi_cs_o  (spi_cs),
        .spi_sdo_o (spi_sdo),
        .spi_sdi_i (spi_sdi)
    );

    assign spi_sdi = loopback ? spi_sdo :
                     ((chip_idx < DB) ? chip_word[DB-1-chip_idx] : 1'b0);

    // Chip shifts out MSB first: first bit at CS fall, next bit at each SCK fall.
    always begin
        @(posedge clk);
        #1;
        if (chip_prev_cs && !spi_cs) chip_idx = 0;
        else if (chip_prev_sck && !spi_sck) chip_idx = chip_idx + 1;
        chip_prev_cs  = spi_cs;
        chip_prev_sck = spi_sck;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT (cycle %0d)", name, cyc);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model and per-cycle compare
    // ------------------------------------------------------------------
    bit            active = 1'b0;
    bit            rel_pending = 1'b1;
    int            o = 0;
    logic [DB-1:0] w_cur = '0;
    logic [DB-1:0] rx_cur = '0;
    logic [DB-1:0] exp_rx_data = '0;
    int            acc_cyc_last = -1;
    int            acc_cyc_prev = -1;
    int            cs_low_run = 0, last_cs_low = 0;
    int            rise_run = 0, last_rises = 0;
    int            gap_run = 0, last_gap = 0;
    int            rxv_run = 0, last_rxv = 0;
    logic          prev_cs_s = 1'b1, prev_sck_s = 1'b0, prev_busy_s = 1'b0;
    logic [DB-1:0] rx_q[$];

    always @(negedge clk) begin
        logic e_cs, e_sck, e_sdo, e_rdy, e_busy, e_rxv;
        bit   idle;
        bit   can_acc;
        int   p, k, h;
        cyc++;
        e_cs = 1'b1; e_sck = 1'b0; e_sdo = 1'b0;
        e_rdy = 1'b0; e_busy = 1'b0; e_rxv = 1'b0;
        can_acc = 1'b0;
        if (reset_i) begin
            rel_pending = 1'b1;
            active      = 1'b0;
            exp_rx_data = '0;
        end else if (rel_pending) begin
            rel_pending = 1'b0;
        end else begin
            if (active) o++;
            idle = !active || (o > FRAME + CG);
            if (idle) begin
                e_rdy = 1'b1;
            end else if (o <= FRAME) begin
                e_cs   = 1'b0;
                e_busy = 1'b1;
                if (o <= CD) begin
                    e_sdo = w_cur[DB-1];
                end else begin
                    p = o - CD - 1;
                    k = p / (2 * CD);
                    h = p % (2 * CD);
                    if (h < CD) begin
                        e_sck = 1'b1;
                        e_sdo = w_cur[DB-1-k];
                    end else begin
                        e_sdo = (k < DB - 1) ? w_cur[DB-2-k] : w_cur[0];
                    end
                end
            end else begin
                e_busy = 1'b1;
                if (o == FRAME + 1) begin
                    e_rxv       = 1'b1;
                    exp_rx_data = rx_cur;
                end
            end
            if (idle) active = 1'b0;
            can_acc = idle;
        end

        check("spi_cs",   32'(spi_cs),   32'(e_cs));
        check("spi_sck",  32'(spi_sck),  32'(e_sck));
        check("spi_sdo",  32'(spi_sdo),  32'(e_sdo));
        check("tx_ready", 32'(tx_ready), 32'(e_rdy));
        check("busy",     32'(busy),     32'(e_busy));
        check("rx_valid", 32'(rx_valid), 32'(e_rxv));
        check("rx_data",  32'(rx_data),  32'(exp_rx_data));

        if (can_acc && tx_valid) begin
            active       = 1'b1;
            o            = 0;
            w_cur        = tx_data;
            rx_cur       = loopback ? tx_data : chip_word;
            acc_cyc_prev = acc_cyc_last;
            acc_cyc_last = cyc;
        end

        // frame statistics from the observed pins
        if (prev_cs_s && !spi_cs) begin
            cs_low_run = 0; rise_run = 0; rxv_run = 0; gap_run = 0;
        end
        if (!spi_cs) cs_low_run++;
        if (!prev_sck_s && spi_sck) rise_run++;
        if (!prev_cs_s && spi_cs) begin
            last_cs_low = cs_low_run;
            last_rises  = rise_run;
        end
        if (spi_cs && busy) gap_run++;
        if (rx_valid) begin
            rxv_run++;
            rx_q.push_back(rx_data);
        end
        if (prev_busy_s && !busy) begin
            last_gap = gap_run;
            last_rxv = rxv_run;
        end
        prev_cs_s   = spi_cs;
        prev_sck_s  = spi_sck;
        prev_busy_s = busy;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_ready(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * PERIOD && !ok; i++) begin
            @(negedge clk);
            if (tx_ready) ok = 1'b1;
        end
        if (!ok) timeout_fail(name);
    endtask

    task automatic send(input logic [DB-1:0] w, input bit lb, input logic [DB-1:0] cw);
        @(posedge clk);
        #1;
        loopback  = lb;
        chip_word = cw;
        tx_data   = w;
        tx_valid  = 1'b1;
        wait_ready("send_accept");
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(output logic [DB-1:0] got, input bit noise);
        bit ok;
        ok  = 1'b0;
        got = '0;
        for (int i = 0; i < 2 * PERIOD && !ok; i++) begin
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            if (rx_valid) begin
                got = rx_data;
                ok  = 1'b1;
            end else if (noise) begin
                tx_data = DB'($urandom);
                if (!spi_cs && ($urandom_range(0, 15) == 0)) tx_valid = 1'b1;
            end
        end
        if (!ok) timeout_fail("wait_rx");
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [DB-1:0] got;
        logic [DB-1:0] w, cw;
        bit            lb;
        logic          psck;
        int            rises;

        // 1: reset held five cycles, ready rises one cycle after release
        reset_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_cs",  32'(spi_cs),   32'd1);
        check("rst_sck", 32'(spi_sck),  32'd0);
        check("rst_sdo", 32'(spi_sdo),  32'd0);
        check("rst_rdy", 32'(tx_ready), 32'd0);
        reset_i = 1'b0;
        @(posedge clk);
        #1;
        check("rdy_after_release", 32'(tx_ready), 32'd1);

        // 2: single loopback frame
        send(24'hA5C3F0, 1'b1, '0);
        wait_rx(got, 1'b0);
        check("loop_rx_word", 32'(got), 32'h00A5C3F0);
        repeat (3) @(posedge clk);
        check("loop_cs_low_cycles", 32'(last_cs_low), 32'd196);
        check("loop_sck_rises",     32'(last_rises),  32'd24);
        check("loop_rx_pulses",     32'(last_rxv),    32'd1);
        check("loop_gap_cycles",    32'(last_gap),    32'd2);

        // 3: back-to-back with tx_valid held
        rx_q.delete();
        @(posedge clk);
        #1;
        loopback = 1'b1;
        tx_data  = 24'h000001;
        tx_valid = 1'b1;
        wait_ready("b2b_first");
        @(posedge clk);
        #1;
        tx_data = 24'hFFFFFE;
        wait_ready("b2b_second");
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        wait_rx(got, 1'b0);
        repeat (3) @(posedge clk);
        check("b2b_accept_spacing", 32'(acc_cyc_last - acc_cyc_prev), 32'd199);
        check("b2b_rx_count",       32'(rx_q.size()),                 32'd2);
        if (rx_q.size() == 2) begin
            check("b2b_rx0", 32'(rx_q[0]), 32'h00000001);
            check("b2b_rx1", 32'(rx_q[1]), 32'h00FFFFFE);
        end
        check("b2b_gap_cycles", 32'(last_gap), 32'd2);

        // 4: chip drives its own word
        send(24'h0F0F0F, 1'b0, 24'h123456);
        wait_rx(got, 1'b0);
        check("chip_rx_word", 32'(got), 32'h00123456);

        // 5: reset at the tenth SCK rise
        repeat (3) @(posedge clk);
        rx_q.delete();
        send(24'hC0FFEE, 1'b1, '0);
        rises = 0;
        psck  = spi_sck;
        for (int i = 0; i < 2 * PERIOD && rises < 10; i++) begin
            @(posedge clk);
            #1;
            if (spi_sck && !psck) rises++;
            psck = spi_sck;
        end
        if (rises < 10) timeout_fail("sck_rise_10");
        reset_i = 1'b1;
        #1;
        check("midrst_cs",  32'(spi_cs),  32'd1);
        check("midrst_sck", 32'(spi_sck), 32'd0);
        check("midrst_sdo", 32'(spi_sdo), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_rx", 32'(rx_q.size()), 32'd0);
        send(24'h5A5A5A, 1'b1, '0);
        wait_rx(got, 1'b0);
        check("after_rst_rx", 32'(got), 32'h005A5A5A);
        repeat (3) @(posedge clk);
        check("after_rst_rises", 32'(last_rises), 32'd24);

        // 6: tx_valid pulsed mid-frame is ignored
        send(24'h3C3C3C, 1'b1, '0);
        repeat (40) @(posedge clk);
        #1;
        tx_data  = 24'hDEAD00;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        wait_rx(got, 1'b0);
        check("ignore_rx_word", 32'(got), 32'h003C3C3C);
        repeat (3) @(posedge clk);
        check("ignore_cs_low", 32'(last_cs_low), 32'd196);
        check("ignore_rises",  32'(last_rises),  32'd24);

        // randomized frames with mid-frame noise on tx_valid / tx_data
        for (int n = 0; n < 20; n++) begin
            w  = DB'($urandom);
            cw = DB'($urandom);
            lb = 1'($urandom_range(0, 1));
            send(w, lb, cw);
            wait_rx(got, 1'b1);
            check("rand_rx_word", 32'(got), 32'(lb ? w : cw));
            repeat ($urandom_range(2, 5)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule
